icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the IF stage's PC/instruction port and a multi-cycle backing instruction memory.
- On a hit, it returns the instruction in the same cycle.
- On a miss, it raises stall, refills one line word-by-word over a valid-only memory interface, then serves the access.
- The stall output feeds the existing PcWrite/IRWrite hold path. A flush input invalidates the whole cache, for program reload.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/icache_refill_ctl.sv | 86 ++++++++
 rtl/icache_dm.sv | 122 ++++++++++++
 tb/tb_icache_dm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants, FSM encoding and address-split width helpers for the
// instruction-side cache.
package mips_pkg;

    localparam int INST_W   = 32;
    localparam int BYTE_OFF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int words);
        return INST_W - BYTE_OFF - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_refill_ctl.sv
// Line-refill sequencer: IDLE/REFILL FSM, beat counter, line-address latch,
// pending-flush flag and the valid-only memory handshake.
module icache_refill_ctl
    import mips_pkg::*;
#(
    parameter int WORDS  = 4,
    parameter int LINE_W = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [LINE_W-1:0]        i_line,
    input  logic                     i_inv_all,
    input  logic                     i_mem_valid,
    output logic                     o_busy,
    output logic                     o_mem_req,
    output logic [INST_W-1:0]        o_mem_addr,
    output logic                     o_we,
    output logic                     o_last,
    output logic [off_w(WORDS)-1:0]  o_beat,
    output logic [LINE_W-1:0]        o_line,
    output logic                     o_fill_valid
);

    localparam int OFF_W = off_w(WORDS);

    state_t              r_state;
    state_t              w_next;
    logic [OFF_W-1:0]    r_beat;
    logic [LINE_W-1:0]   r_line;
    logic                r_flush_pend;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (i_start) begin
                r_line <= i_line;
                r_beat <= '0;
            end else if (o_we) begin
                r_beat <= r_beat + 1'b1;
            end
            if (o_last)
                r_flush_pend <= 1'b0;
            else if (r_state == REFILL && i_inv_all)
                r_flush_pend <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_we   = 1'b0;
        o_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start)
                    w_next = REFILL;
            end
            REFILL: begin
                o_busy = 1'b1;
                o_we   = i_mem_valid;
                if (i_mem_valid && r_beat == OFF_W'(WORDS - 1)) begin
                    o_last = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_mem_req    = o_busy;
    assign o_mem_addr   = {r_line, r_beat, 2'b00};
    assign o_beat       = r_beat;
    assign o_line       = r_line;
    // A flush seen earlier in the refill, or on the last beat itself, leaves the line invalid.
    assign o_fill_valid = ~r_flush_pend & ~i_inv_all;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: register-array storage, zero-latency
// hit compare, saturating hit/miss statistics and the refill controller.
module icache_dm
    import mips_pkg::*;
#(
    parameter int LINES = 8,
    parameter int WORDS = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] cpu_addr,
    input  logic              cpu_req,
    output logic [INST_W-1:0] cpu_inst,
    output logic              cpu_ready,
    output logic              stall,
    input  logic              inv_all,
    output logic              mem_req,
    output logic [INST_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int OFF_W  = off_w(WORDS);
    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = tag_w(LINES, WORDS);
    localparam int LINE_W = INST_W - BYTE_OFF - OFF_W;

    logic [INST_W-1:0] r_data [LINES][WORDS];
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINES-1:0]  r_valid;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_start;
    logic              w_busy;
    logic              w_we;
    logic              w_last;
    logic              w_fill_valid;
    logic [OFF_W-1:0]  w_beat;
    logic [LINE_W-1:0] w_line;
    logic [IDX_W-1:0]  w_fidx;
    logic [TAG_W-1:0]  w_ftag;
    logic              w_unused_bits;

    assign w_off = cpu_addr[OFF_W+BYTE_OFF-1 : BYTE_OFF];
    assign w_idx = cpu_addr[IDX_W+OFF_W+BYTE_OFF-1 : OFF_W+BYTE_OFF];
    assign w_tag = cpu_addr[INST_W-1 : IDX_W+OFF_W+BYTE_OFF];
    assign w_unused_bits = ^cpu_addr[BYTE_OFF-1:0];

    // Lookups only happen in IDLE; there is no hit-under-miss.
    assign w_hit     = cpu_req & ~w_busy & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_start   = cpu_req & ~w_busy & ~w_hit;
    assign cpu_ready = w_hit;
    assign cpu_inst  = r_data[w_idx][w_off];
    assign stall     = cpu_req & ~w_hit;

    assign w_fidx = w_line[IDX_W-1:0];
    assign w_ftag = w_line[LINE_W-1:IDX_W];

    icache_refill_ctl #(
        .WORDS  (WORDS),
        .LINE_W (LINE_W)
    ) u_refill_ctl (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_line       (cpu_addr[INST_W-1:OFF_W+BYTE_OFF]),
        .i_inv_all    (inv_all),
        .i_mem_valid  (mem_valid),
        .o_busy       (w_busy),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .o_we         (w_we),
        .o_last       (w_last),
        .o_beat       (w_beat),
        .o_line       (w_line),
        .o_fill_valid (w_fill_valid)
    );

    // NOTE: data and tag arrays have no reset; the valid bits alone decide
    // whether their contents are ever observed.
    always_ff @(posedge clk) begin
        if (w_we && !rst)
            r_data[w_fidx][w_beat] <= mem_rdata;
        if (w_last && !rst)
            r_tag[w_fidx] <= w_ftag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (inv_all)
                r_valid <= '0;
            if (w_last)
                r_valid[w_fidx] <= w_fill_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_start && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, same-line hit, conflict eviction,
// backpressured refill, flushes, counter saturation and reset mid-refill.
module tb_icache_dm;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_req;
    logic        inv_all;
    logic        mem_valid;
    wire  [31:0] mem_rdata;
    wire  [31:0] cpu_inst;
    wire         cpu_ready;
    wire         stall;
    wire         mem_req;
    wire  [31:0] mem_addr;
    wire  [15:0] hit_cnt;
    wire  [15:0] miss_cnt;

    wire  [31:0] unused_inst2;
    wire         unused_ready2;
    wire         unused_stall2;
    wire         unused_req2;
    wire  [31:0] unused_addr2;
    wire  [1:0]  hit_cnt2;
    wire  [1:0]  miss_cnt2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    // Backing memory: each word encodes its own byte address.
    assign mem_rdata = {16'hC0DE, mem_addr[15:0]};

    icache_dm #(.LINES(8), .WORDS(WORDS), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_req   (cpu_req),
        .cpu_inst  (cpu_inst),
        .cpu_ready (cpu_ready),
        .stall     (stall),
        .inv_all   (inv_all),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    // Same stimulus, 2-bit counters, to exercise saturation.
    icache_dm #(.LINES(8), .WORDS(WORDS), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_req   (cpu_req),
        .cpu_inst  (unused_inst2),
        .cpu_ready (unused_ready2),
        .stall     (unused_stall2),
        .inv_all   (inv_all),
        .mem_req   (unused_req2),
        .mem_addr  (unused_addr2),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt2),
        .miss_cnt  (miss_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a fetch that must miss in IDLE; leaves the DUT entering REFILL.
    task automatic miss_start(input logic [31:0] addr);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        #1;
        check("miss_stall", stall, 1);
        check("miss_ready", cpu_ready, 0);
        check("miss_memreq_idle", mem_req, 0);
        exp_miss++;
        tick();
    endtask

    // Drive one refill; pat bit i is mem_valid in REFILL cycle i.
    task automatic refill(input logic [31:0] base, input logic [15:0] pat,
                          input int inv_cycle, input int exp_len);
        int cyc   = 0;
        int beats = 0;
        while (mem_req === 1'b1 && cyc < 40) begin
            mem_valid = (cyc < 16) ? pat[cyc] : 1'b1;
            inv_all   = (cyc == inv_cycle);
            #1;
            check("refill_addr", mem_addr, base + 32'(beats * 4));
            check("refill_stall", stall, 1);
            check("refill_ready", cpu_ready, 0);
            if (mem_valid) beats++;
            @(posedge clk);
            #1;
            cyc++;
        end
        mem_valid = 1'b0;
        inv_all   = 1'b0;
        check("refill_len", cyc, exp_len);
        check("refill_beats", beats, WORDS);
    endtask

    task automatic expect_hit(input logic [31:0] addr);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        #1;
        check("hit_ready", cpu_ready, 1);
        check("hit_stall", stall, 0);
        check("hit_inst", cpu_inst, {16'hC0DE, addr[15:0]});
        check("hit_memreq", mem_req, 0);
        exp_hit++;
        tick();
    endtask

    task automatic check_counters();
        cpu_req = 1'b0;
        #1;
        check("stall_noreq", stall, 0);
        check("hit_cnt", hit_cnt, exp_hit);
        check("miss_cnt", miss_cnt, exp_miss);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = 32'h0;
        inv_all   = 1'b0;
        mem_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", cpu_ready, 0);
        check("rst_stall", stall, 0);
        check("rst_memreq", mem_req, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);

        // Cold miss at 0x40 with memory answering every cycle.
        miss_start(32'h40);
        refill(32'h40, 16'hFFFF, -1, 4);
        expect_hit(32'h40);
        check_counters();
        check("cold_miss_is_1", miss_cnt, 1);
        check("cold_hit_is_1", hit_cnt, 1);

        // Same-line hit, third refill word.
        expect_hit(32'h48);
        check_counters();

        // Conflict on index 4: 0xC0 evicts 0x40 and vice versa.
        miss_start(32'hC0);
        refill(32'hC0, 16'hFFFF, -1, 4);
        expect_hit(32'hC0);
        miss_start(32'h40);
        refill(32'h40, 16'hFFFF, -1, 4);
        expect_hit(32'h40);
        check_counters();
        check("conflict_miss_is_3", miss_cnt, 3);

        // inv_all in IDLE: same-cycle hit still reported, next lookup misses.
        cpu_req  = 1'b1;
        cpu_addr = 32'h40;
        inv_all  = 1'b1;
        #1;
        check("inv_idle_hit", cpu_ready, 1);
        exp_hit++;
        tick();
        inv_all = 1'b0;
        miss_start(32'h40);
        // inv_all on beat 1: refill completes but the line stays invalid.
        refill(32'h40, 16'hFFFF, 1, 4);
        miss_start(32'h40);
        refill(32'h40, 16'hFFFF, -1, 4);
        expect_hit(32'h40);
        check_counters();

        // Backpressure: mem_valid 1,0,0,1,0,1,1 across 7 REFILL cycles.
        miss_start(32'h100);
        refill(32'h100, 16'h0069, -1, 7);
        expect_hit(32'h100);
        expect_hit(32'h104);
        expect_hit(32'h108);
        expect_hit(32'h10C);
        check_counters();

        check("sat_hit_cnt", hit_cnt2, (exp_hit > 3) ? 3 : exp_hit);
        check("sat_miss_cnt", miss_cnt2, (exp_miss > 3) ? 3 : exp_miss);

        // Reset on beat 2 of a 0x140 refill.
        miss_start(32'h140);
        mem_valid = 1'b1;
        #1;
        check("rr_beat0", mem_addr, 32'h140);
        tick();
        #1;
        check("rr_beat1", mem_addr, 32'h144);
        tick();
        rst = 1'b1;
        #1;
        check("rr_beat2", mem_addr, 32'h148);
        tick();
        rst       = 1'b0;
        mem_valid = 1'b0;
        cpu_req   = 1'b0;
        exp_hit   = 0;
        exp_miss  = 0;
        #1;
        check("rr_memreq", mem_req, 0);
        check_counters();
        check("rr_sat_hit", hit_cnt2, 0);
        // Late mem_valid pulse in IDLE is ignored.
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        #1;
        check("late_valid_memreq", mem_req, 0);
        check_counters();

        // All lines were invalidated: previously resident lines miss.
        miss_start(32'h100);
        refill(32'h100, 16'hFFFF, -1, 4);
        expect_hit(32'h100);
        miss_start(32'h40);
        refill(32'h40, 16'hFFFF, -1, 4);
        expect_hit(32'h40);
        check_counters();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
